rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the register file's single write port between the pipeline writeback stage (port 0)
//  and a multi-cycle result source such as MUL/DIV (port 1). Port-0 writes go straight to the
//  port with zero latency. Port-1 results are held in a small pending buffer and drained into
//  idle write slots. The block flags reads that hit pending registers and requests a pipeline
//  stall when a buffered result has waited too long. Sits between MEM/WB, the multi-cycle unit
//  and RegFile.
// PARAMETERS
//  DEPTH        2   pending-buffer entries (power of 2, >=2)
//  STARVE_LIMIT 4   consecutive undrained cycles of a valid head before stall_req asserts
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   asynchronous reset, active-high
//  wb_we      in   1   pipeline writeback enable (port 0)
//  wb_waddr   in   5   port-0 destination register
//  wb_wdata   in   32  port-0 data
//  mc_valid   in   1   multi-cycle result valid (port 1)
//  mc_ready   out  1   port-1 accept; transfer when mc_valid & mc_ready
//  mc_waddr   in   5   port-1 destination register
//  mc_wdata   in   32  port-1 data
//  rf_we      out  1   to RegFile we
//  rf_waddr   out  5   to RegFile waddr
//  rf_wdata   out  32  to RegFile wdata
//  re1/raddr1 in   1/5 ID read port 1 (snooped)
//  re2/raddr2 in   1/5 ID read port 2 (snooped)
//  pend_hit1  out  1   raddr1 has an outstanding port-1 write; ID must stall
//  pend_hit2  out  1   same for raddr2
//  stall_req  out  1   request to freeze upstream and inject a WB bubble
// BEHAVIOUR
//  Reset: buffer empty, pointers/count/starve counter = 0, stall_req = 0. While rst=1, all
//   outputs are 0 (mc_ready=0, rf_we=0, pend_hit*=0).
//  Address 0 is never written. wb_we with wb_waddr=0 is treated as idle. A port-1 transfer
//   to address 0 is accepted and discarded.
//  Port 0 has absolute priority. If wb_we & wb_waddr!=0, rf_* = wb_* combinationally in the
//   same cycle.
//  Drain: if port 0 is idle and the head entry is valid, rf_we=1 with the head addr/data, and
//   the head pops at the clock edge.
//  Squashed heads: an invalid (squashed) head pops without a write, at most 1 pop per cycle.
//  Buffer entry fields: {valid, addr[4:0], data[31:0]}. FIFO order by head/tail pointers, wrap
//   mod DEPTH.
//  mc_ready = (count < DEPTH). It must not depend on a same-cycle pop; this avoids a
//   combinational path. Enqueue and pop in the same cycle are allowed, and count is unchanged.
//  Squash (program order): a port-0 write to addr A clears valid on every buffered entry with
//   addr==A. A port-1 transfer with mc_waddr==A in the same cycle is accepted and dropped,
//   since port 0 is younger.
//  pend_hit_n = re_n & raddr_n!=0 & (some valid entry addr==raddr_n | (mc_valid & mc_ready &
//   mc_waddr==raddr_n)). Entries squashed this cycle still count as hits this cycle.
//  Starve counter:
//   - increments each cycle the head is valid and not drained;
//   - clears on any pop or when the buffer is empty;
//   - saturates at STARVE_LIMIT.
//  stall_req: set (registered) when the counter reaches STARVE_LIMIT; cleared the cycle after
//   the head drains.
//  Reset mid-operation discards all buffered entries. No write reaches RegFile after reset.
// STRUCTURE
//  Shared constants come from define.v: `RegAddrBus, `RegBus, `RegNumLog2, `WriteEnable,
//   `ZeroWord, `RstEnable.
//  Sub-module rf_pend_buf: DEPTH-entry FIFO with a per-entry valid bit, address-match squash
//   and two CAM match outputs. The top level holds the priority mux, ready logic and starve
//   counter/stall FSM (IDLE / WAIT / STALL).
// TESTING
//  1 Port-0 only:
//    wb_we=1, addr 3, data 0xA5A5A5A5 -> rf_we=1, addr 3, same data, same cycle; mc_ready=1.
//  2 Idle drain:
//    mc transfer (7, 0x11) with wb_we=0 next cycle -> rf_we=1, addr 7, data 0x11 one cycle
//    after the transfer; pend_hit1=1 for raddr1=7 until then.
//  3 Full/backpressure (DEPTH=2):
//    two mc transfers while wb_we=1 every cycle (other addrs) -> mc_ready=0 after 2 transfers;
//    a third mc_valid waits; after wb_we drops, entries drain in order, one per cycle.
//  4 Squash:
//    buffer holds (5, 0x1); wb write (5, 0x2) -> entry invalidated; the later idle slot
//    produces no write; RegFile ends with 0x2.
//  5 Starvation:
//    one entry buffered and wb_we=1 continuously -> stall_req=1 after 4 cycles; bench bubbles
//    WB -> drain occurs and stall_req=0 the next cycle.
//  6 Async reset with 2 entries buffered:
//    rst pulse mid-cycle -> all outputs 0 immediately; after release, no drain writes and
//    mc_ready=1.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, buffer entry payload and starve-FSM state encoding for the
// register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_NUM    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;
  localparam reg_data_t ZERO_WORD = '0;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } pend_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } starve_state_e;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Write-port bundle: writeback port, multi-cycle result port, RegFile write
// port, ID read snoop and hazard/stall flags.
interface rf_wport_arbiter_if;
  import rf_wport_arbiter_pkg::*;

  logic      wb_we;
  reg_addr_t wb_waddr;
  reg_data_t wb_wdata;

  logic      mc_valid;
  logic      mc_ready;
  reg_addr_t mc_waddr;
  reg_data_t mc_wdata;

  logic      rf_we;
  reg_addr_t rf_waddr;
  reg_data_t rf_wdata;

  logic      re1;
  reg_addr_t raddr1;
  logic      re2;
  reg_addr_t raddr2;

  logic      pend_hit1;
  logic      pend_hit2;
  logic      stall_req;

  modport slave (
    input  wb_we, wb_waddr, wb_wdata,
    input  mc_valid, mc_waddr, mc_wdata,
    output mc_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  re1, raddr1, re2, raddr2,
    output pend_hit1, pend_hit2, stall_req
  );

  modport master (
    output wb_we, wb_waddr, wb_wdata,
    output mc_valid, mc_waddr, mc_wdata,
    input  mc_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output re1, raddr1, re2, raddr2,
    input  pend_hit1, pend_hit2, stall_req
  );

endinterface

// File: rtl/rf_pend_buf.sv
// Pending-write FIFO for port-1 results: per-entry valid bit, address-match
// squash and two read-address CAM match outputs.
module rf_pend_buf
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  reg_addr_t i_push_addr,
  input  reg_data_t i_push_data,
  input  logic      i_pop,
  input  logic      i_squash,
  input  reg_addr_t i_squash_addr,
  input  reg_addr_t i_raddr1,
  input  reg_addr_t i_raddr2,
  output logic      o_head_valid,
  output reg_addr_t o_head_addr,
  output reg_data_t o_head_data,
  output logic      o_empty,
  output logic      o_full,
  output logic      o_match1,
  output logic      o_match2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pend_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Valid is cleared on pop so the CAM only needs to look at valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (i_squash && (r_mem[i].addr == i_squash_addr)) begin
          r_mem[i].valid <= 1'b0;
        end
      end
      if (i_pop) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + PTR_W'(1);
      end
      if (i_push) begin
        r_mem[r_tail] <= '{valid: 1'b1, addr: i_push_addr, data: i_push_data};
        r_tail        <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_comb begin
    o_empty      = (r_count == '0);
    o_full       = (r_count == CNT_W'(DEPTH));
    o_head_valid = r_mem[r_head].valid && !o_empty;
    o_head_addr  = r_mem[r_head].addr;
    o_head_data  = r_mem[r_head].data;
  end

  always_comb begin
    o_match1 = 1'b0;
    o_match2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_mem[i].valid && (r_mem[i].addr == i_raddr1)) o_match1 = 1'b1;
      if (r_mem[i].valid && (r_mem[i].addr == i_raddr2)) o_match2 = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RegFile write port between writeback (priority) and buffered
// multi-cycle results; flags pending-read hazards and requests a stall on starvation.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  rf_wport_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic          w_wb_act;
  logic          w_mc_ready;
  logic          w_xfer;
  logic          w_push;
  logic          w_drain;
  logic          w_pop;
  logic          w_head_valid;
  reg_addr_t     w_head_addr;
  reg_data_t     w_head_data;
  logic          w_empty;
  logic          w_full;
  logic          w_match1;
  logic          w_match2;
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_next;
  starve_state_e r_state;
  starve_state_e w_state_next;
  logic          r_stall_req;

  rf_pend_buf #(.DEPTH(DEPTH)) u_pend_buf (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_addr  (bus.mc_waddr),
    .i_push_data  (bus.mc_wdata),
    .i_pop        (w_pop),
    .i_squash     (w_wb_act),
    .i_squash_addr(bus.wb_waddr),
    .i_raddr1     (bus.raddr1),
    .i_raddr2     (bus.raddr2),
    .o_head_valid (w_head_valid),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_match1     (w_match1),
    .o_match2     (w_match2)
  );

  // Ready looks only at registered occupancy, never at a same-cycle pop.
  always_comb begin
    w_wb_act   = bus.wb_we && (bus.wb_waddr != ZERO_ADDR);
    w_mc_ready = !w_full;
    w_xfer     = bus.mc_valid && w_mc_ready;
    w_push     = w_xfer && (bus.mc_waddr != ZERO_ADDR) &&
                 !(w_wb_act && (bus.wb_waddr == bus.mc_waddr));
    w_drain    = !w_wb_act && w_head_valid;
    w_pop      = !w_empty && (w_drain || !w_head_valid);
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = ZERO_ADDR;
    bus.rf_wdata = ZERO_WORD;
    if (!rst) begin
      if (w_wb_act) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_waddr;
        bus.rf_wdata = bus.wb_wdata;
      end else if (w_drain) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = w_head_addr;
        bus.rf_wdata = w_head_data;
      end
    end
  end

  // A transfer in flight this cycle already counts as pending for ID.
  always_comb begin
    bus.mc_ready  = !rst && w_mc_ready;
    bus.pend_hit1 = !rst && bus.re1 && (bus.raddr1 != ZERO_ADDR) &&
                    (w_match1 || (w_xfer && (bus.mc_waddr == bus.raddr1)));
    bus.pend_hit2 = !rst && bus.re2 && (bus.raddr2 != ZERO_ADDR) &&
                    (w_match2 || (w_xfer && (bus.mc_waddr == bus.raddr2)));
    bus.stall_req = r_stall_req;
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || w_empty) begin
      w_starve_next = '0;
    end else if (w_head_valid && !w_drain && (r_starve != SW'(STARVE_LIMIT))) begin
      w_starve_next = r_starve + SW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_starve_next == SW'(STARVE_LIMIT)) w_state_next = ST_STALL;
        else if (w_starve_next != '0)           w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_starve_next == SW'(STARVE_LIMIT)) w_state_next = ST_STALL;
        else if (w_starve_next == '0)           w_state_next = ST_IDLE;
      end
      ST_STALL: begin
        if (w_starve_next == '0) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve    <= '0;
      r_state     <= ST_IDLE;
      r_stall_req <= 1'b0;
    end else begin
      r_starve    <= w_starve_next;
      r_state     <= w_state_next;
      r_stall_req <= (w_state_next == ST_STALL);
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: the driver queues expected RegFile
// writes, a negedge monitor pops and compares every write the DUT issues.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  wr_t       exp_q[$];
  reg_data_t model_rf [REG_NUM];
  int        n_checks = 0;
  int        n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_in();
    bus.wb_we    = 1'b0;
    bus.wb_waddr = '0;
    bus.wb_wdata = '0;
    bus.mc_valid = 1'b0;
    bus.mc_waddr = '0;
    bus.mc_wdata = '0;
    bus.re1      = 1'b0;
    bus.raddr1   = '0;
    bus.re2      = 1'b0;
    bus.raddr2   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic wb(input int a, input logic [31:0] d, input bit exp_write);
    bus.wb_we    = 1'b1;
    bus.wb_waddr = REG_ADDR_W'(a);
    bus.wb_wdata = d;
    if (exp_write) exp_q.push_back('{addr: REG_ADDR_W'(a), data: d});
  endtask

  task automatic mc(input int a, input logic [31:0] d);
    bus.mc_valid = 1'b1;
    bus.mc_waddr = REG_ADDR_W'(a);
    bus.mc_wdata = d;
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    exp_q.push_back('{addr: REG_ADDR_W'(a), data: d});
  endtask

  // Monitor: every RegFile write must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst && bus.rf_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(e.addr));
        chk("wr_data", bus.rf_wdata, e.data);
      end
      model_rf[bus.rf_waddr] = bus.rf_wdata;
    end
  end

  initial begin
    for (int i = 0; i < int'(REG_NUM); i++) model_rf[i] = '0;
    idle_in();
    rst = 1'b1;
    wb(3, 32'hDEAD_BEEF, 1'b0);
    #2;
    chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset_mc_ready", 32'(bus.mc_ready), 32'd0);
    chk("reset_stall", 32'(bus.stall_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle_in();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_mc_ready", 32'(bus.mc_ready), 32'd1);
    chk("post_reset_stall", 32'(bus.stall_req), 32'd0);

    // Port-0 only: same-cycle write
    step(); wb(3, 32'hA5A5_A5A5, 1'b1);
    @(negedge clk);
    chk("t1_mc_ready", 32'(bus.mc_ready), 32'd1);
    chk("t1_rf_waddr", 32'(bus.rf_waddr), 32'd3);

    // Idle drain one cycle after transfer, with read-hazard flag
    step(); mc(7, 32'h11); bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    @(negedge clk);
    chk("t2_hit_xfer", 32'(bus.pend_hit1), 32'd1);
    chk("t2_no_write_yet", 32'(bus.rf_we), 32'd0);
    step(); bus.re1 = 1'b1; bus.raddr1 = 5'd7; expect_wr(7, 32'h11);
    @(negedge clk);
    chk("t2_hit_buffered", 32'(bus.pend_hit1), 32'd1);
    step(); bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    @(negedge clk);
    chk("t2_hit_cleared", 32'(bus.pend_hit1), 32'd0);

    // Backpressure at DEPTH=2, then in-order drain
    step(); wb(10, 32'hA0, 1'b1); mc(8, 32'h80);
    @(negedge clk); chk("t3_ready0", 32'(bus.mc_ready), 32'd1);
    step(); wb(11, 32'hB0, 1'b1); mc(9, 32'h90);
    @(negedge clk); chk("t3_ready1", 32'(bus.mc_ready), 32'd1);
    step(); wb(12, 32'hC0, 1'b1); mc(13, 32'hD0);
    @(negedge clk); chk("t3_full", 32'(bus.mc_ready), 32'd0);
    step(); mc(13, 32'hD0); expect_wr(8, 32'h80);
    @(negedge clk); chk("t3_full_drain", 32'(bus.mc_ready), 32'd0);
    step(); mc(13, 32'hD0); expect_wr(9, 32'h90);
    @(negedge clk); chk("t3_ready_again", 32'(bus.mc_ready), 32'd1);
    step(); expect_wr(13, 32'hD0);
    @(negedge clk); chk("t3_stall", 32'(bus.stall_req), 32'd0);
    step();
    @(negedge clk); chk("t3_quiet", 32'(bus.rf_we), 32'd0);

    // Squash: younger port-0 write kills the buffered entry
    step(); wb(20, 32'h20, 1'b1); mc(5, 32'h1);
    step(); wb(5, 32'h2, 1'b1); bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    @(negedge clk); chk("t4_hit_squashed", 32'(bus.pend_hit2), 32'd1);
    step(); bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    @(negedge clk);
    chk("t4_no_drain", 32'(bus.rf_we), 32'd0);
    chk("t4_hit_gone", 32'(bus.pend_hit2), 32'd0);
    chk("t4_rf5", model_rf[5], 32'h2);

    // Starvation: stall_req after 4 undrained cycles, clears after drain
    step(); wb(21, 32'h21, 1'b1); mc(6, 32'h66);
    for (int k = 1; k <= 5; k++) begin
      step(); wb(21 + k, 32'h100 + 32'(k), 1'b1);
      @(negedge clk);
      if (k == 4) chk("t5_stall_pre", 32'(bus.stall_req), 32'd0);
      if (k == 5) chk("t5_stall_set", 32'(bus.stall_req), 32'd1);
    end
    step(); expect_wr(6, 32'h66);
    @(negedge clk); chk("t5_stall_drain_cycle", 32'(bus.stall_req), 32'd1);
    step();
    @(negedge clk); chk("t5_stall_clear", 32'(bus.stall_req), 32'd0);

    // Async reset with two entries buffered
    step(); wb(27, 32'h27, 1'b1); mc(14, 32'hE);
    step(); wb(28, 32'h28, 1'b1); mc(15, 32'hF);
    step();
    wb(30, 32'h30, 1'b0); mc(16, 32'h16);
    bus.re1 = 1'b1; bus.raddr1 = 5'd14; bus.re2 = 1'b1; bus.raddr2 = 5'd16;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("t6_rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("t6_rst_mc_ready", 32'(bus.mc_ready), 32'd0);
    chk("t6_rst_hit1", 32'(bus.pend_hit1), 32'd0);
    chk("t6_rst_hit2", 32'(bus.pend_hit2), 32'd0);
    chk("t6_rst_stall", 32'(bus.stall_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle_in();
    bus.re1 = 1'b1; bus.raddr1 = 5'd14;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_mc_ready", 32'(bus.mc_ready), 32'd1);
    chk("t6_hit_cleared", 32'(bus.pend_hit1), 32'd0);
    repeat (3) step();
    @(negedge clk);
    chk("t6_no_drain", 32'(bus.rf_we), 32'd0);
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
